// File: rtl/lock_pkg.sv
// Shared types and default parameters for the code-lock front end.
package lock_pkg;

   localparam int unsigned W_DEF           = 4;
   localparam logic [3:0]  CODE_A_DEF      = 4'b0101;
   localparam logic [3:0]  CODE_B_DEF      = 4'b0100;
   localparam int unsigned MAX_FAIL_DEF    = 3;
   localparam int unsigned LOCK_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      CHECK   = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter timing the lockout window; done flags the final cycle.
module lockout_timer #(
   parameter int unsigned LOCK_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic done
);

   localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);

   logic [TW-1:0] count;

   // Load has priority; ticking stops at zero so the counter never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= TW'(LOCK_CYCLES);
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == TW'(1));

endmodule

// File: rtl/code_lock_sequencer.sv
// Keypad front end: accepts a code word, shifts it out MSB-first, checks it
// against the unlock/clear codes and enforces a timed lockout on repeated failure.
module code_lock_sequencer
   import lock_pkg::*;
#(
   parameter int unsigned W           = W_DEF,
   parameter logic [W-1:0] CODE_A     = W'(CODE_A_DEF),
   parameter logic [W-1:0] CODE_B     = W'(CODE_B_DEF),
   parameter int unsigned MAX_FAIL    = MAX_FAIL_DEF,
   parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         ser_x,
   output logic         ser_en,
   output logic         unlock,
   output logic         clear,
   output logic         fail,
   output logic         locked,
   output logic [1:0]   fail_cnt
);

   localparam int unsigned BW         = $clog2(W);
   localparam logic [1:0]  MAX_FAIL_C = 2'(MAX_FAIL);

   state_t          state, state_next;
   logic [W-1:0]    shreg;
   logic [W-1:0]    rx;
   logic [BW-1:0]   bit_cnt;
   logic            hit_a, hit_b, lock_hit;
   logic [1:0]      fail_cnt_inc;
   logic            timer_load, timer_done;

   // CODE_A is tested first, so it wins if both codes are equal.
   assign hit_a        = (rx == CODE_A);
   assign hit_b        = (rx == CODE_B);
   assign fail_cnt_inc = fail_cnt + 2'd1;
   assign lock_hit     = (fail_cnt_inc == MAX_FAIL_C);
   assign timer_load   = (state == CHECK) && !hit_a && !hit_b && lock_hit;

   lockout_timer #(
      .LOCK_CYCLES(LOCK_CYCLES)
   ) u_timer (
      .clk  (clk),
      .reset(reset),
      .load (timer_load),
      .tick (state == LOCKOUT),
      .done (timer_done)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = SHIFT;
         SHIFT:   if (bit_cnt == BW'(W - 1)) state_next = CHECK;
         CHECK:   state_next = timer_load ? LOCKOUT : IDLE;
         LOCKOUT: if (timer_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs; shreg is zero outside SHIFT, so ser_x idles low.
   always_comb begin
      in_ready = (state == IDLE);
      ser_en   = (state == SHIFT);
      ser_x    = shreg[W-1];
   end

   // Datapath and registered result outputs; pulses self-clear each cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg    <= '0;
         rx       <= '0;
         bit_cnt  <= '0;
         unlock   <= 1'b0;
         clear    <= 1'b0;
         fail     <= 1'b0;
         locked   <= 1'b0;
         fail_cnt <= 2'd0;
      end else begin
         unlock <= 1'b0;
         clear  <= 1'b0;
         fail   <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg   <= in_data;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               shreg   <= {shreg[W-2:0], 1'b0};
               rx      <= {rx[W-2:0], shreg[W-1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
            CHECK: begin
               if (hit_a) begin
                  unlock   <= 1'b1;
                  fail_cnt <= 2'd0;
               end else if (hit_b) begin
                  clear    <= 1'b1;
                  fail_cnt <= 2'd0;
               end else begin
                  fail <= 1'b1;
                  if (lock_hit) begin
                     fail_cnt <= 2'd0;
                     locked   <= 1'b1;
                  end else begin
                     fail_cnt <= fail_cnt_inc;
                  end
               end
            end
            LOCKOUT: begin
               if (timer_done) locked <= 1'b0;
            end
            default: begin
               shreg    <= '0;
               rx       <= '0;
               bit_cnt  <= '0;
               locked   <= 1'b0;
               fail_cnt <= 2'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/code_lock_sequencer.md
# code_lock_sequencer

Front-end controller for the serial code-lock datapath. It accepts 4-bit code words from the keypad through a valid/ready handshake and shifts each word MSB-first onto a bit-serial line feeding the lock detector. In parallel it checks the word against the unlock and clear codes, counts failed attempts, and enforces a timed lockout after too many failures.

## Interface
- W, 4, code word width (fixed for this block).
- CODE_A, 4'b0101, unlock code.
- CODE_B, 4'b0100, clear code: resets the fail counter without unlocking.
- MAX_FAIL, 3, consecutive failures that trigger lockout; range 1..3.
- LOCK_CYCLES, 16, lockout duration in clk cycles; must be at least 1.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  keypad word offered.
- in_data  in  W  keypad word.
- in_ready  out  1  word accepted on a clk edge when in_valid & in_ready.
- ser_x  out  1  serial bit to detector; current MSB of the shift register.
- ser_en  out  1  ser_x valid this cycle.
- unlock  out  1  one-cycle pulse, word == CODE_A.
- clear  out  1  one-cycle pulse, word == CODE_B.
- fail  out  1  one-cycle pulse, word matched neither code.
- locked  out  1  level, high during lockout.
- fail_cnt  out  2  current consecutive-failure count.

## Operation
- States:
  - IDLE: in_ready=1. On handshake, load shreg←in_data, bit_cnt←0, go to SHIFT.
  - SHIFT: ser_en=1 and ser_x=shreg[W-1]. Each cycle: shreg shifts left (0 in), rx←{rx[W-2:0],ser_x}, bit_cnt++. After W cycles, go to CHECK.
  - CHECK: compare rx. Priority order is CODE_A, then CODE_B, then fail.
    - CODE_A: unlock←1, fail_cnt←0, go to IDLE.
    - CODE_B: clear←1, fail_cnt←0, go to IDLE.
    - Neither: fail←1, fail_cnt+1.
      - If the new count == MAX_FAIL: fail_cnt←0, timer←LOCK_CYCLES, locked←1, go to LOCKOUT.
      - Otherwise go to IDLE.
  - LOCKOUT: in_ready=0. timer decrements each cycle. On the cycle timer==1: locked←0, go to IDLE.
- Output registration:
  - in_ready and ser_en are decoded from state.
  - unlock, clear, fail, locked and fail_cnt are registered.
  - Each pulse is cleared on the cycle after it is set.
- in_valid asserted outside IDLE is ignored. The source holds the word until in_ready.
- CODE_A == CODE_B: CODE_A wins and clear never fires.
- fail_cnt never exceeds MAX_FAIL-1 while visible.
- Illegal state encodings return to IDLE with all outputs cleared.

## Timing
- Reset values:
  - State IDLE, so in_ready=1.
  - ser_en=0, ser_x=0.
  - unlock=clear=fail=locked=0, fail_cnt=0.
  - shreg, rx, bit_cnt and timer all 0.
- Handshake at edge E0:
  - ser_en high for cycles E0..E4. Bits MSB-first are sampled by the detector at E1..E4.
  - State is CHECK after E4.
  - The result pulse is high between E5 and E6.
  - in_ready returns after E5, or after lockout ends.
- Throughput is one word per 6 cycles when no lockout occurs.
- Lockout:
  - locked rises at E5 and stays high exactly LOCK_CYCLES cycles.
  - in_ready rises on the same edge locked falls.
- Reset mid-SHIFT or mid-LOCKOUT:
  - Returns immediately to the reset values.
  - The partial word is discarded and no pulse is emitted.
  - The fail count and lockout are cleared.

## Structure
- Package lock_pkg holds:
  - The state enum: IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2, LOCKOUT=2'd3.
  - Default CODE_A, CODE_B and W.
  - MAX_FAIL and LOCK_CYCLES defaults.
- Sub-module lockout_timer:
  - Loadable down-counter of width $clog2(LOCK_CYCLES+1), with load, tick and done outputs.
  - Instantiated once.
- Everything else lives in the top FSM.

## Test plan
- After reset, offer 4'b0101. Required: ser_x = 0,1,0,1 with ser_en high for 4 cycles; unlock pulses exactly once 5 cycles after the handshake; fail_cnt=0.
- Offer 4'b0011 twice, then 4'b0100. Required: fail pulses twice with fail_cnt 1 then 2; then clear pulses and fail_cnt=0; locked stays 0.
- Offer 4'b1111 three times. Required: the third word gives fail and locked=1 for 16 cycles, with in_ready=0 throughout; a word held on in_valid during lockout is accepted on the first cycle in_ready is 1.
- Hold in_valid continuously with 4'b0101. Required: handshakes exactly 6 cycles apart; one unlock per word.
- Assert reset after the 2nd serial bit of 4'b0101. Required: no unlock; all outputs at reset values on the next sample; the next word is processed normally.
- Build with MAX_FAIL=1 and LOCK_CYCLES=1 and offer 4'b0000. Required: fail and locked high for exactly 1 cycle, then in_ready=1.
